// File: rtl/uart_alu_iface.sv
// ----------------------------------------------------------------------------
// uart_alu_iface
//
// Byte-serial ALU front end for a UART. Three bytes are pulled from the UART
// receive buffer (operand A, operand B, opcode); the result is computed as the
// opcode byte is consumed and is written back to the UART transmitter as one
// byte. An inter-byte timeout abandons a partially received transaction.
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   reset    in   asynchronous, active-low reset
//   rx_empty in   UART receive buffer empty (0 = r_data holds a valid byte)
//   r_data   in   UART received byte [DBIT]
//   tx_full  in   UART transmit buffer occupied (1 = write not accepted)
//   rd_uart  out  one-cycle pulse consuming the byte on r_data
//   wr_uart  out  one-cycle pulse loading w_data into the transmitter
//   w_data   out  result byte [DBIT]
//   state_o  out  current FSM state (00 WAIT_A, 01 WAIT_B, 10 WAIT_OP, 11 SEND)
//
// Parameters
//   DBIT     operand/byte width (must equal the UART byte width, >= 6)
//   TIMEOUT  inter-byte timeout in clk cycles, 0 disables it
//   TO_BITS  timeout counter width, 2**TO_BITS > TIMEOUT
// ----------------------------------------------------------------------------
module uart_alu_iface #(
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 50_000_000,
  parameter int TO_BITS = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  input  logic            tx_full,
  output logic            rd_uart,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [1:0]      state_o
);

  localparam logic [1:0] WAIT_A  = 2'b00;
  localparam logic [1:0] WAIT_B  = 2'b01;
  localparam logic [1:0] WAIT_OP = 2'b10;
  localparam logic [1:0] SEND    = 2'b11;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam bit                 TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_EN ? TO_BITS'(TIMEOUT - 1) : '0;
  // Shift amounts at or above the operand width saturate to all-zero or
  // all-sign rather than relying on the operator's out-of-range behaviour.
  localparam logic [DBIT-1:0]    SH_LIM  = DBIT'(DBIT);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [DBIT-1:0]    a_reg;
  logic [DBIT-1:0]    b_reg;
  logic [TO_BITS-1:0] to_cnt;
  logic [TO_BITS-1:0] to_cnt_next;
  logic               to_fire;

  // Result of one ALU operation; only the low six opcode bits select it.
  function automatic logic [DBIT-1:0] alu_result(
    input logic [DBIT-1:0] a,
    input logic [DBIT-1:0] b,
    input logic [5:0]      op
  );
    logic signed [DBIT-1:0] a_s;
    logic signed [DBIT-1:0] sra_s;
    logic [DBIT-1:0]        res;
    a_s   = a;
    sra_s = a_s >>> b;
    res   = '0;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRA: res = (b >= SH_LIM) ? {DBIT{a[DBIT-1]}} : sra_s;
      OP_SRL: res = (b >= SH_LIM) ? '0 : (a >> b);
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_next = state;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    to_fire    = 1'b0;
    case (state)
      WAIT_A: begin
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        // An arriving byte wins over a timeout expiring in the same cycle.
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          state_next = WAIT_OP;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          to_fire    = 1'b1;
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          state_next = SEND;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          to_fire    = 1'b1;
          state_next = WAIT_A;
        end
      end
      default: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = WAIT_A;
        end
      end
    endcase
    // Strobes must be low while reset is held, even with a byte waiting.
    if (!reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
    end
  end

  // The counter only runs while waiting for B or OP and restarts on every
  // state change, so it measures the gap since the last accepted byte.
  always_comb begin
    to_cnt_next = '0;
    if (TO_EN && (state_next == state) && ((state == WAIT_B) || (state == WAIT_OP)))
      to_cnt_next = to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= WAIT_A;
      to_cnt <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      w_data <= '0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
      if (to_fire) begin
        a_reg <= '0;
        b_reg <= '0;
      end else if (rd_uart) begin
        case (state)
          WAIT_A:  a_reg  <= r_data;
          WAIT_B:  b_reg  <= r_data;
          // The opcode is used straight off r_data so the result is ready
          // in the first SEND cycle.
          WAIT_OP: w_data <= alu_result(a_reg, b_reg, r_data[5:0]);
          default: ;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: doc/uart_alu_iface.md
UART_ALU_IFACE -- requirements
Module: uart_alu_iface

Interface
REQ-001 Parameter DBIT, default 8: data/operand width; SHALL equal the UART byte width.
REQ-002 Parameter TIMEOUT, default 50_000_000: inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-003 Parameter TO_BITS, default 26: timeout counter width; SHALL satisfy 2^TO_BITS > TIMEOUT.
REQ-004 clk  input  1  single system clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_empty  input  1  UART receive buffer empty; 0 = byte valid on r_data.
REQ-007 r_data  input  DBIT  UART received byte, stable while rx_empty=0.
REQ-008 tx_full  input  1  UART transmit buffer occupied; 1 = no write accepted.
REQ-009 rd_uart  output  1  one-cycle pulse consuming the byte on r_data.
REQ-010 wr_uart  output  1  one-cycle pulse loading w_data into the UART transmitter.
REQ-011 w_data  output  DBIT  result byte to transmit.
REQ-012 state_o  output  2  current FSM state encoding, for LEDs/debug.

Function
REQ-013 FSM states SHALL be WAIT_A (00), WAIT_B (01), WAIT_OP (10), SEND (11).
REQ-014 In WAIT_A/WAIT_B/WAIT_OP, rd_uart SHALL be asserted combinationally exactly when rx_empty=0; on that edge r_data is captured into A, B or OP and the FSM advances WAIT_A->WAIT_B->WAIT_OP->SEND.
REQ-015 rd_uart SHALL never be asserted in SEND, nor when rx_empty=1.
REQ-016 On the WAIT_OP->SEND edge, the result SHALL be computed from A, B, OP[5:0] and registered into w_data; OP[7:6] ignored.
REQ-017 Opcodes: 0x20 ADD A+B; 0x22 SUB A-B; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x03 SRA A>>>B; 0x02 SRL A>>B; any other opcode gives 0x00.
REQ-018 ADD/SUB SHALL wrap modulo 2^DBIT, no carry output; shifts use B as unsigned amount, amounts >= DBIT give 0x00 (SRL) or replicated sign bit of A (SRA).
REQ-019 In SEND, wr_uart SHALL be asserted for one cycle when tx_full=0, then FSM returns to WAIT_A; while tx_full=1, FSM holds in SEND with wr_uart=0 and w_data stable.
REQ-020 Bytes arriving while in SEND SHALL remain unread in the UART buffer and be consumed as operand A after returning to WAIT_A.
REQ-021 Timeout counter SHALL clear on every state change and increment each cycle in WAIT_B and WAIT_OP; on reaching TIMEOUT-1 without a received byte the FSM SHALL return to WAIT_A, discarding A/B.
REQ-022 If a byte arrives in the same cycle the timeout expires, the byte SHALL be accepted and the timeout ignored.
REQ-023 Counter SHALL stay at 0 in WAIT_A and SEND; with TIMEOUT=0 no timeout SHALL occur.
REQ-024 Throughput: one complete transaction (3 reads, 1 write) SHALL take at minimum 4 cycles when bytes and tx space are immediately available.

Reset
REQ-025 reset=0 SHALL immediately force state WAIT_A, A=B=OP=0, w_data=0x00, timeout counter 0, rd_uart=0, wr_uart=0, state_o=00, independent of clk.
REQ-026 Reset asserted mid-transaction SHALL discard all captured operands; first cycle after release SHALL be WAIT_A.

Verification
REQ-027 Bytes 0x05, 0x03, 0x20 with tx_full=0 -> three rd_uart pulses, then one wr_uart pulse with w_data=0x05+0x03=0x08, state back to 00.
REQ-028 A=0x80, B=0x02, OP=0x03 -> w_data=0xE0; OP=0x02 -> w_data=0x20; A=0x03, B=0x05, OP=0x22 -> w_data=0xFE.
REQ-029 A=0x0F, B=0xF0, OP=0x3F (invalid) -> w_data=0x00; OP=0xE4 (upper bits set, AND) -> w_data=0x00 computed as AND.
REQ-030 Hold tx_full=1 for 20 cycles in SEND while a new byte is pending -> no wr_uart, no rd_uart, w_data stable; release -> single wr_uart, then pending byte read as A.
REQ-031 TIMEOUT=10: send 0x11 then nothing -> after 10 cycles in WAIT_B state_o=00; next bytes 0x01,0x02,0x20 -> w_data=0x03.
REQ-032 Assert reset while in WAIT_OP -> outputs at reset values asynchronously; after release, sequence 0x04,0x04,0x26 -> w_data=0x00 with exactly one wr_uart.
